// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU, single-cycle logic/arith, iterative mul/div.
// Define ALU_SEQ_MULDIV_EN to build the shift-add mul / restoring div path.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             div_zero,
  output logic             illegal_op
);

`ifdef ALU_SEQ_MULDIV_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DONE = 2'd2
  } state_t;
`endif

  state_t state_q, state_d;

  logic accept;
  logic is_add, is_sub, is_mul, is_div;
  logic is_and, is_xor, is_or, is_nota;
  logic [WIDTH:0]   sum, dif;
  logic [WIDTH-1:0] q_res, q_hi;
  logic             q_cy, q_dz, q_il;

  assign in_ready  = rst_n & (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid & in_ready;

  assign is_add  = (op == 3'b000);
  assign is_sub  = (op == 3'b001);
  assign is_mul  = (op == 3'b010);
  assign is_div  = (op == 3'b011);
  assign is_and  = (op == 3'b100);
  assign is_xor  = (op == 3'b101);
  assign is_or   = (op == 3'b110);
  assign is_nota = (op == 3'b111);

  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};

`ifdef ALU_SEQ_MULDIV_EN
  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]    cnt;
  logic             is_mul_q;
  logic [WIDTH-1:0] w_hi, w_lo, w_b;
  logic [WIDTH-1:0] n_hi, n_lo;
  logic [WIDTH:0]   madd, shl;
  logic             go_calc, last;

  assign last = (state_q == CALC) && (cnt == CW'(WIDTH - 1));

  // One iteration: mul keeps {w_hi,w_lo} as partial product / multiplier,
  // div keeps w_hi as remainder and shifts quotient bits into w_lo.
  always_comb begin
    n_hi = w_hi;
    n_lo = w_lo;
    madd = '0;
    shl  = '0;
    if (is_mul_q) begin
      madd = {1'b0, w_hi} + (w_lo[0] ? {1'b0, w_b} : '0);
      n_hi = madd[WIDTH:1];
      n_lo = {madd[0], w_lo[WIDTH-1:1]};
    end else begin
      shl = {w_hi, w_lo[WIDTH-1]};
      if (shl >= {1'b0, w_b}) begin
        n_hi = shl[WIDTH-1:0] - w_b;
        n_lo = {w_lo[WIDTH-2:0], 1'b1};
      end else begin
        n_hi = shl[WIDTH-1:0];
        n_lo = {w_lo[WIDTH-2:0], 1'b0};
      end
    end
  end
`endif

  always_comb begin
    q_res = '0;
    q_hi  = '0;
    q_cy  = 1'b0;
    q_dz  = 1'b0;
    q_il  = 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
    go_calc = 1'b0;
`endif
    unique case (1'b1)
      is_add: begin
        q_res = sum[WIDTH-1:0];
        q_cy  = sum[WIDTH];
      end
      is_sub: begin
        q_res = dif[WIDTH-1:0];
        q_cy  = dif[WIDTH];
      end
`ifdef ALU_SEQ_MULDIV_EN
      is_mul: go_calc = 1'b1;
      is_div: begin
        if (b == '0) begin
          q_res = '1;
          q_hi  = a;
          q_dz  = 1'b1;
        end else begin
          go_calc = 1'b1;
        end
      end
`else
      is_mul: q_il = 1'b1;
      is_div: q_il = 1'b1;
`endif
      is_and:  q_res = a & b;
      is_xor:  q_res = a ^ b;
      is_or:   q_res = a | b;
      is_nota: q_res = ~a;
      default: q_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef ALU_SEQ_MULDIV_EN
          state_d = go_calc ? CALC : DONE;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef ALU_SEQ_MULDIV_EN
      CALC: if (last) state_d = DONE;
`endif
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result     <= '0;
      result_hi  <= '0;
      carry      <= 1'b0;
      div_zero   <= 1'b0;
      illegal_op <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
      cnt        <= '0;
      is_mul_q   <= 1'b0;
      w_hi       <= '0;
      w_lo       <= '0;
      w_b        <= '0;
`endif
    end else if (accept) begin
      result     <= q_res;
      result_hi  <= q_hi;
      carry      <= q_cy;
      div_zero   <= q_dz;
      illegal_op <= q_il;
`ifdef ALU_SEQ_MULDIV_EN
      cnt        <= '0;
      is_mul_q   <= is_mul;
      w_hi       <= '0;
      w_lo       <= is_mul ? b : a;
      w_b        <= is_mul ? a : b;
`endif
    end
`ifdef ALU_SEQ_MULDIV_EN
    else if (state_q == CALC) begin
      cnt  <= cnt + CW'(1);
      w_hi <= n_hi;
      w_lo <= n_lo;
      if (last) begin
        result    <= n_lo;
        result_hi <= n_hi;
      end
    end
`endif
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed literal checks plus randomized traffic against
// a behavioural model; a per-cycle compare process checks the handshake.
module tb_alu_seq;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [2:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid;
  logic         carry, div_zero, illegal_op;
  logic [W-1:0] result, result_hi;

  int checks = 0;
  int errors = 0;
  bit en = 1'b0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .result_hi  (result_hi),
    .carry      (carry),
    .div_zero   (div_zero),
    .illegal_op (illegal_op)
  );

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         cy;
    logic         dz;
    logic         il;
    int           lat;
  } exp_t;

  function automatic exp_t model(input logic [2:0] o,
                                 input logic [W-1:0] x,
                                 input logic [W-1:0] y);
    exp_t e;
    logic [63:0] xx, yy, p;
    xx = 64'(x);
    yy = 64'(y);
    e.res = '0;
    e.hi  = '0;
    e.cy  = 1'b0;
    e.dz  = 1'b0;
    e.il  = 1'b0;
    e.lat = 1;
    case (o)
      3'd0: begin
        p = xx + yy;
        e.res = p[W-1:0];
        e.cy  = p[W];
      end
      3'd1: begin
        e.res = x - y;
        e.cy  = (x < y);
      end
`ifdef ALU_SEQ_MULDIV_EN
      3'd2: begin
        p = xx * yy;
        e.res = p[W-1:0];
        e.hi  = p[2*W-1:W];
        e.lat = W + 1;
      end
      3'd3: begin
        if (y == 0) begin
          e.res = '1;
          e.hi  = x;
          e.dz  = 1'b1;
        end else begin
          e.res = x / y;
          e.hi  = x % y;
          e.lat = W + 1;
        end
      end
`else
      3'd2: e.il = 1'b1;
      3'd3: e.il = 1'b1;
`endif
      3'd4: e.res = x & y;
      3'd5: e.res = x ^ y;
      3'd6: e.res = x | y;
      default: e.res = ~x;
    endcase
    return e;
  endfunction

  // Model: one command in flight, counted in cycles since acceptance.
  bit   busy = 1'b0;
  bit   fresh = 1'b1;
  int   elapsed = 0;
  exp_t m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  = 1'b0;
      fresh = 1'b1;
    end else if (!busy) begin
      if (in_valid) begin
        busy    = 1'b1;
        elapsed = 1;
        m       = model(op, a, b);
        fresh   = 1'b0;
      end
    end else if (elapsed >= m.lat) begin
      if (out_ready) busy = 1'b0;
    end else begin
      elapsed++;
    end
  end

  always @(negedge clk) begin
    bit ok;
    bit eiv, eov;
    if (en) begin
      if (!rst_n) begin
        eiv = 1'b0;
        eov = 1'b0;
        ok = (in_ready === 1'b0) && (out_valid === 1'b0) &&
             (result === '0) && (result_hi === '0) &&
             ({carry, div_zero, illegal_op} === 3'b000);
      end else begin
        eiv = !busy;
        eov = busy && (elapsed >= m.lat);
        ok = (in_ready === eiv) && (out_valid === eov);
        if (eov)
          ok = ok && (result === m.res) && (result_hi === m.hi) &&
               ({carry, div_zero, illegal_op} === {m.cy, m.dz, m.il});
        else if (fresh)
          ok = ok && (result === '0) && (result_hi === '0) &&
               ({carry, div_zero, illegal_op} === 3'b000);
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL cycle@%0t rst_n=%b ready %b want %b valid %b want %b res %h/%h want %h/%h flags %b%b%b want %b%b%b",
                 $time, rst_n, in_ready, eiv, out_valid, eov,
                 result, result_hi, m.res, m.hi,
                 carry, div_zero, illegal_op, m.cy, m.dz, m.il);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_wait", 64'(in_ready), 64'd1);
    op = o;
    a = x;
    b = y;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 3'($urandom);
    a = W'($urandom);
    b = W'($urandom);
  endtask

  task automatic lit(input string nm, input logic [2:0] o,
                     input logic [W-1:0] x, input logic [W-1:0] y,
                     input logic [W-1:0] er, input logic [W-1:0] eh,
                     input logic [2:0] efl, input int elat);
    int n = 0;
    issue(o, x, y);
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_lat"}, 64'(n + 1), 64'(elat));
    chk({nm, "_res"}, 64'(result), 64'(er));
    chk({nm, "_hi"}, 64'(result_hi), 64'(eh));
    chk({nm, "_flags"}, 64'({carry, div_zero, illegal_op}), 64'(efl));
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1 en = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("reset_ready", 64'(in_ready), 64'd1);
    chk("reset_result", 64'({result, result_hi}), 64'd0);

    lit("add_wrap", 3'd0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0, 3'b100, 1);
    lit("sub_borrow", 3'd1, 16'd3, 16'd5, 16'hFFFE, 16'h0, 3'b100, 1);
    lit("and", 3'd4, 16'hF0F0, 16'h0FF0, 16'h00F0, 16'h0, 3'b000, 1);
    lit("or", 3'd6, 16'hF000, 16'h000F, 16'hF00F, 16'h0, 3'b000, 1);
    lit("nota", 3'd7, 16'h1234, 16'hFFFF, 16'hEDCB, 16'h0, 3'b000, 1);
`ifdef ALU_SEQ_MULDIV_EN
    lit("mul_max", 3'd2, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 3'b000, 17);
    lit("div", 3'd3, 16'd1000, 16'd7, 16'd142, 16'd6, 3'b000, 17);
    lit("div_zero", 3'd3, 16'd5, 16'd0, 16'hFFFF, 16'd5, 3'b010, 1);
`else
    lit("mul_ill", 3'd2, 16'hFFFF, 16'hFFFF, 16'h0, 16'h0, 3'b001, 1);
    lit("div_ill", 3'd3, 16'd1000, 16'd7, 16'h0, 16'h0, 3'b001, 1);
    lit("div0_ill", 3'd3, 16'd5, 16'd0, 16'h0, 16'h0, 3'b001, 1);
`endif
    lit("add_clr", 3'd0, 16'd1, 16'd1, 16'd2, 16'h0, 3'b000, 1);

    out_ready = 1'b0;
    issue(3'd5, 16'h1234, 16'h00FF);
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (5) begin
      @(posedge clk); #1;
      chk("hold_res", 64'(result), 64'h12CB);
      chk("hold_ready", 64'({in_ready, out_valid}), 64'b01);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release", 64'({in_ready, out_valid}), 64'b10);

    issue(3'd2, 16'h1234, 16'h5678);
    repeat (7) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_out", 64'({result, result_hi}), 64'd0);
    chk("midrst_hs", 64'({in_ready, out_valid}), 64'b00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("midrst_ready", 64'(in_ready), 64'd1);
    lit("add_after_rst", 3'd0, 16'd2, 16'd2, 16'd4, 16'h0, 3'b000, 1);

    repeat (4000) begin
      @(posedge clk); #1;
      in_valid  = 1'($urandom_range(0, 1));
      op        = 3'($urandom);
      a = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 50))
                                      : W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 599) != 0);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 16, operand and result width in bits; legal range 4..64.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  request valid; command is accepted when in_valid and in_ready are both high.
REQ-005 in_ready  output  1  block can accept a command.
REQ-006 op  input  3  opcode: 000 add, 001 sub, 010 mul, 011 div, 100 and, 101 xor, 110 or, 111 not-a.
REQ-007 a, b  input  WIDTH  operands, unsigned.
REQ-008 out_valid  output  1  result valid.
REQ-009 out_ready  input  1  consumer accepts the result when out_valid and out_ready are both high.
REQ-010 result  output  WIDTH  sum, difference, product low half, quotient or logic result.
REQ-011 result_hi  output  WIDTH  product high half for mul, remainder for div, otherwise 0.
REQ-012 carry  output  1  add: carry-out; sub: borrow (a<b); otherwise 0.
REQ-013 div_zero  output  1  the div result was produced with b==0.
REQ-014 illegal_op  output  1  the opcode is not supported in this build.

Function
REQ-015 The FSM SHALL have states IDLE, CALC and DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 On acceptance, a, b and op SHALL be registered; input changes after acceptance SHALL have no effect.
REQ-017 For ops add, sub, and, xor, or and not-a, the FSM SHALL go IDLE->DONE; out_valid SHALL rise on the cycle after acceptance (latency 1).
REQ-018 For mul, the FSM SHALL go IDLE->CALC, run WIDTH shift-add iterations (one per cycle) and then go to DONE; out_valid SHALL rise WIDTH+1 cycles after acceptance; {result_hi,result} SHALL equal the full 2*WIDTH-bit product.
REQ-019 For div with b!=0, the block SHALL perform restoring division over WIDTH cycles in CALC with the same latency as mul; result SHALL be the quotient and result_hi the remainder.
REQ-020 For div with b==0, the block SHALL skip CALC and use latency 1; result SHALL be all ones, result_hi SHALL be a, and div_zero SHALL be 1.
REQ-021 Add/sub SHALL wrap modulo 2^WIDTH.
REQ-022 The iteration counter SHALL be $clog2(WIDTH)+1 bits wide; CALC SHALL exit when the counter reaches WIDTH-1.
REQ-023 In DONE, all outputs SHALL hold stable until out_ready=1; the FSM SHALL then go to IDLE on that edge.
REQ-024 There is no DONE->CALC bypass; back-to-back throughput SHALL be one command per latency+1 cycles minimum.
REQ-025 out_ready while out_valid=0 SHALL be ignored; in_valid outside IDLE SHALL be ignored (not queued).
REQ-026 div_zero, illegal_op and carry SHALL describe the current result only, and SHALL be cleared on the next acceptance.

Reset
REQ-027 When rst_n=0, the FSM SHALL go to IDLE immediately, including in the middle of an operation; the in-flight command SHALL be discarded.
REQ-028 During reset, in_ready=0; after reset, in_ready=1; out_valid, result, result_hi, carry, div_zero, illegal_op and the counter SHALL all be 0.

Configuration
REQ-029 Macro ALU_SEQ_MULDIV_EN: when defined, mul and div SHALL be built as specified above.
REQ-030 When ALU_SEQ_MULDIV_EN is not defined:
- the mul/div datapath and CALC SHALL be omitted;
- op 010 and op 011 SHALL complete with latency 1, result=0, result_hi=0, illegal_op=1;
- all other ops SHALL be unchanged.

Verification (WIDTH=16, out_ready=1 unless stated)
REQ-031 add a=16'hFFFF, b=16'h0001 -> 1 cycle later result=0, carry=1, out_valid=1.
REQ-032 sub a=3, b=5 -> result=16'hFFFE, carry=1; and a=16'hF0F0, b=16'h0FF0 -> result=16'h00F0.
REQ-033 mul a=16'hFFFF, b=16'hFFFF -> out_valid after 17 cycles; result=16'h0001, result_hi=16'hFFFE; in_ready=0 throughout.
REQ-034 div a=1000, b=7 -> after 17 cycles result=142, result_hi=6; div a=5, b=0 -> after 1 cycle result=16'hFFFF, result_hi=5, div_zero=1.
REQ-035 xor result held with out_ready=0 for 5 cycles -> result stable, in_ready=0; out_ready=1 -> next cycle in_ready=1, out_valid=0.
REQ-036 rst_n pulsed low at cycle 8 of a mul -> outputs 0 immediately, in_ready=1 after release; next add 2+2 -> result=4.
